// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad, debounces one key and
// decodes it into a held digit/op_code value plus a one-cycle event pulse.
//   clk         system clock, rising edge
//   clear       async active-high reset
//   col_n[3:0]  keypad columns, active-low, async to clk
//   row_n[3:0]  one-hot active-low row drive
//   digit       last accepted digit (0-9)
//   op_code     last accepted operator (00 + 01 - 10 x 11 /)
//   num_pressed / op_selected / equal / key_clear  one-cycle event pulses
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] digit,
  output logic [1:0] op_code,
  output logic       num_pressed,
  output logic       op_selected,
  output logic       equal,
  output logic       key_clear
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEB,
    S_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    sync1, cs;
  logic [CW-1:0] slot_q;
  logic [1:0]    row_q;
  logic [DW-1:0] match_q, match_d;
  logic [DW-1:0] rel_q, rel_d;
  logic [3:0]    cand_q, cand_d;
  logic          tick, one_low, adv, accept;
  logic [1:0]    col_idx;
  logic          is_dig, is_op, is_eq, is_clr;
  logic [3:0]    dig_val;

  assign tick = (slot_q == SLOT_LAST);

  always_comb begin
    one_low = 1'b1;
    col_idx = 2'd0;
    case (cs)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  // state register and datapath
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sync1       <= 4'hF;
      cs          <= 4'hF;
      slot_q      <= '0;
      row_q       <= 2'd0;
      state_q     <= S_SCAN;
      match_q     <= '0;
      rel_q       <= '0;
      cand_q      <= 4'hF;
      digit       <= 4'd0;
      op_code     <= 2'd0;
      num_pressed <= 1'b0;
      op_selected <= 1'b0;
      equal       <= 1'b0;
      key_clear   <= 1'b0;
    end else begin
      sync1       <= col_n;
      cs          <= sync1;
      slot_q      <= tick ? '0 : slot_q + CW'(1);
      state_q     <= state_d;
      match_q     <= match_d;
      rel_q       <= rel_d;
      cand_q      <= cand_d;
      if (adv)
        row_q <= row_q + 2'd1;
      num_pressed <= accept & is_dig;
      op_selected <= accept & is_op;
      equal       <= accept & is_eq;
      key_clear   <= accept & is_clr;
      if (accept && is_dig)
        digit <= dig_val;
      if (accept && is_op)
        op_code <= row_q;
    end
  end

  // next state; the row stays frozen outside SCAN, so the
  // candidate's row is always row_q
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    rel_d   = rel_q;
    cand_d  = cand_q;
    adv     = 1'b0;
    accept  = 1'b0;
    if (tick) begin
      unique case (state_q)
        S_SCAN: begin
          if (one_low) begin
            cand_d  = cs;
            match_d = DW'(1);
            if (DEBOUNCE_CNT == 1) begin
              accept  = 1'b1;
              rel_d   = '0;
              state_d = S_HOLD;
            end else begin
              state_d = S_DEB;
            end
          end else begin
            adv = 1'b1;
          end
        end
        S_DEB: begin
          if (cs == cand_q) begin
            if (match_q == DB_LAST) begin
              accept  = 1'b1;
              rel_d   = '0;
              state_d = S_HOLD;
            end else begin
              match_d = match_q + DW'(1);
            end
          end else begin
            adv     = 1'b1;
            state_d = S_SCAN;
          end
        end
        S_HOLD: begin
          if (cs == 4'hF) begin
            if (rel_q == DB_LAST) begin
              adv     = 1'b1;
              state_d = S_SCAN;
            end else begin
              rel_d = rel_q + DW'(1);
            end
          end else begin
            rel_d = '0;
          end
        end
        default: state_d = S_SCAN;
      endcase
    end
  end

  // outputs: row drive and key decode
  always_comb begin
    row_n   = ~(4'b0001 << row_q);
    is_dig  = 1'b0;
    is_op   = 1'b0;
    is_eq   = 1'b0;
    is_clr  = 1'b0;
    dig_val = 4'd0;
    unique case (1'b1)
      (col_idx == 2'd3): is_op = 1'b1;
      (row_q != 2'd3 && col_idx != 2'd3): begin
        is_dig  = 1'b1;
        dig_val = 4'(row_q) * 4'd3 + 4'(col_idx) + 4'd1;
      end
      (row_q == 2'd3 && col_idx == 2'd0): is_clr = 1'b1;
      (row_q == 2'd3 && col_idx == 2'd1): is_dig = 1'b1;
      (row_q == 2'd3 && col_idx == 2'd2): is_eq = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with a
// behavioural keypad matrix (SCAN_DIV=4, DEBOUNCE_CNT=3).
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] digit;
  logic [1:0] op_code;
  logic       num_pressed, op_selected, equal, key_clear;
  logic [15:0] keys = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_num = 0, n_op = 0, n_eq = 0, n_clr = 0;
  int n_multi = 0, n_rowchg = 0;
  int num_cyc = 0, op_cyc = 0, eq_cyc = 0;
  int row_enter [4];
  logic [3:0] prev_row = 4'b1110;

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_CNT(3)
  ) dut (
    .clk(clk),
    .clear(clear),
    .col_n(col_n),
    .row_n(row_n),
    .digit(digit),
    .op_code(op_code),
    .num_pressed(num_pressed),
    .op_selected(op_selected),
    .equal(equal),
    .key_clear(key_clear)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // key index r*4+c pulls column c low while row r is driven
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_n[r])
          col_n[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (num_pressed) begin n_num++; num_cyc = cyc; end
    if (op_selected) begin n_op++; op_cyc = cyc; end
    if (equal) begin n_eq++; eq_cyc = cyc; end
    if (key_clear) n_clr++;
    if (int'(num_pressed) + int'(op_selected) +
        int'(equal) + int'(key_clear) > 1)
      n_multi++;
    if (row_n != prev_row) begin
      n_rowchg++;
      case (row_n)
        4'b1110: row_enter[0] = cyc;
        4'b1101: row_enter[1] = cyc;
        4'b1011: row_enter[2] = cyc;
        4'b0111: row_enter[3] = cyc;
        default: ;
      endcase
      prev_row = row_n;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    wait_cyc(2);
    checks++;
    if (row_n !== 4'b1110) begin
      errors++; $display("FAIL rst_row: got %b exp 1110", row_n);
    end
    checks++;
    if (digit !== 4'd0) begin
      errors++; $display("FAIL rst_digit: got %0d exp 0", digit);
    end
    checks++;
    if (op_code !== 2'b00) begin
      errors++; $display("FAIL rst_op: got %b exp 00", op_code);
    end
    checks++;
    if ({num_pressed, op_selected, equal, key_clear} !== 4'b0) begin
      errors++;
      $display("FAIL rst_pulses: got %b exp 0000",
               {num_pressed, op_selected, equal, key_clear});
    end
    clear = 1'b0;
    wait_cyc(6);
    checks++;
    if (row_n !== 4'b1101) begin
      errors++; $display("FAIL scan_row1: got %b exp 1101", row_n);
    end
    #2 clear = 1'b1;
    #1;
    checks++;
    if (row_n !== 4'b1110) begin
      errors++; $display("FAIL rst_async_row: got %b exp 1110", row_n);
    end
    wait_cyc(2);
    clear = 1'b0;
  endtask

  task automatic test_digit;
    int b_num, b_oth;
    b_num = n_num;
    b_oth = n_op + n_eq + n_clr;
    keys[5] = 1'b1;
    wait_cyc(200);
    checks++;
    if (n_num - b_num != 1) begin
      errors++; $display("FAIL dig5_count: got %0d exp 1", n_num - b_num);
    end
    checks++;
    if (digit !== 4'd5) begin
      errors++; $display("FAIL dig5_value: got %0d exp 5", digit);
    end
    checks++;
    if (num_cyc - row_enter[1] != 12) begin
      errors++;
      $display("FAIL dig5_latency: got %0d exp 12 from row entry",
               num_cyc - row_enter[1]);
    end
    checks++;
    if (n_op + n_eq + n_clr - b_oth != 0) begin
      errors++;
      $display("FAIL dig5_other: got %0d exp 0", n_op + n_eq + n_clr - b_oth);
    end
    checks++;
    if (row_n !== 4'b1101) begin
      errors++; $display("FAIL dig5_hold_row: got %b exp 1101", row_n);
    end
    keys = '0;
    wait_cyc(60);
  endtask

  task automatic test_op_equal;
    int b_num, b_op, b_eq;
    b_num = n_num; b_op = n_op; b_eq = n_eq;
    keys[11] = 1'b1;
    wait_cyc(80);
    keys = '0;
    wait_cyc(60);
    checks++;
    if (op_code !== 2'b10) begin
      errors++; $display("FAIL op_c_code: got %b exp 10", op_code);
    end
    keys[14] = 1'b1;
    wait_cyc(80);
    keys = '0;
    wait_cyc(60);
    checks++;
    if (n_op - b_op != 1) begin
      errors++; $display("FAIL op_c_count: got %0d exp 1", n_op - b_op);
    end
    checks++;
    if (n_eq - b_eq != 1) begin
      errors++; $display("FAIL eq_count: got %0d exp 1", n_eq - b_eq);
    end
    checks++;
    if (!(op_cyc < eq_cyc)) begin
      errors++;
      $display("FAIL op_eq_order: got op@%0d eq@%0d exp op first",
               op_cyc, eq_cyc);
    end
    checks++;
    if (digit !== 4'd5 || n_num != b_num) begin
      errors++;
      $display("FAIL op_eq_digit: got %0d/%0d pulses exp 5/0",
               digit, n_num - b_num);
    end
    checks++;
    if (op_code !== 2'b10) begin
      errors++; $display("FAIL eq_keeps_op: got %b exp 10", op_code);
    end
  endtask

  task automatic test_digit_table;
    int idx [4] = '{0, 10, 13, 6};
    logic [3:0] exp [4] = '{4'd1, 4'd9, 4'd0, 4'd6};
    int b_num;
    for (int i = 0; i < 4; i++) begin
      b_num = n_num;
      keys[idx[i]] = 1'b1;
      wait_cyc(80);
      checks++;
      if (n_num - b_num != 1 || digit !== exp[i]) begin
        errors++;
        $display("FAIL tbl_key%0d: got digit %0d n %0d exp %0d n 1",
                 idx[i], digit, n_num - b_num, exp[i]);
      end
      keys = '0;
      wait_cyc(60);
    end
    checks++;
    if (op_code !== 2'b10) begin
      errors++; $display("FAIL tbl_op_kept: got %b exp 10", op_code);
    end
  endtask

  task automatic test_star;
    int b_clr, b_oth;
    b_clr = n_clr;
    b_oth = n_num + n_op + n_eq;
    keys[12] = 1'b1;
    wait_cyc(80);
    keys = '0;
    wait_cyc(60);
    checks++;
    if (n_clr - b_clr != 1) begin
      errors++; $display("FAIL star_count: got %0d exp 1", n_clr - b_clr);
    end
    checks++;
    if (digit !== 4'd6 || op_code !== 2'b10) begin
      errors++;
      $display("FAIL star_hold: got %0d/%b exp 6/10", digit, op_code);
    end
    checks++;
    if (n_num + n_op + n_eq - b_oth != 0) begin
      errors++;
      $display("FAIL star_other: got %0d exp 0", n_num + n_op + n_eq - b_oth);
    end
  endtask

  task automatic test_bounce;
    int b_num;
    b_num = n_num;
    for (int i = 0; i < 10; i++) begin
      keys[8] = (i % 2 == 0);
      wait_cyc(4);
    end
    checks++;
    if (n_num - b_num != 0) begin
      errors++; $display("FAIL bounce_quiet: got %0d exp 0", n_num - b_num);
    end
    keys[8] = 1'b1;
    wait_cyc(100);
    checks++;
    if (n_num - b_num != 1 || digit !== 4'd7) begin
      errors++;
      $display("FAIL bounce_accept: got n %0d digit %0d exp 1 7",
               n_num - b_num, digit);
    end
    keys = '0;
    wait_cyc(60);
  endtask

  task automatic test_multi_key;
    int b_all, b_row, b_num;
    b_all = n_num + n_op + n_eq + n_clr;
    b_row = n_rowchg;
    keys[0] = 1'b1;
    keys[1] = 1'b1;
    wait_cyc(100);
    checks++;
    if (n_num + n_op + n_eq + n_clr - b_all != 0) begin
      errors++;
      $display("FAIL multi_nopulse: got %0d exp 0",
               n_num + n_op + n_eq + n_clr - b_all);
    end
    checks++;
    if (n_rowchg - b_row < 4) begin
      errors++;
      $display("FAIL multi_scanning: got %0d row changes exp >=4",
               n_rowchg - b_row);
    end
    keys = '0;
    wait_cyc(20);
    b_num = n_num;
    keys[0] = 1'b1;
    wait_cyc(80);
    keys[1] = 1'b1;
    wait_cyc(80);
    keys[0] = 1'b0;
    wait_cyc(60);
    checks++;
    if (n_num - b_num != 1 || digit !== 4'd1) begin
      errors++;
      $display("FAIL hold_single: got n %0d digit %0d exp 1 1",
               n_num - b_num, digit);
    end
    checks++;
    if (row_n !== 4'b1110) begin
      errors++; $display("FAIL hold_persist: got %b exp 1110", row_n);
    end
    keys = '0;
    b_row = n_rowchg;
    wait_cyc(60);
    checks++;
    if (n_rowchg - b_row == 0) begin
      errors++; $display("FAIL hold_release: got 0 row changes exp >0");
    end
  endtask

  task automatic test_reset_after_keys;
    wait_cyc(7);
    #2 clear = 1'b1;
    #1;
    checks++;
    if (digit !== 4'd0 || op_code !== 2'b00) begin
      errors++;
      $display("FAIL rst2_vals: got %0d/%b exp 0/00", digit, op_code);
    end
    checks++;
    if (row_n !== 4'b1110) begin
      errors++; $display("FAIL rst2_row: got %b exp 1110", row_n);
    end
    wait_cyc(2);
    clear = 1'b0;
  endtask

  task automatic test_reset_mid_debounce;
    int b_op;
    b_op = n_op;
    keys[15] = 1'b1;
    for (int i = 0; i < 40 && row_n !== 4'b0111; i++)
      @(negedge clk);
    checks++;
    if (row_n !== 4'b0111) begin
      errors++; $display("FAIL mid_deb_row3: got %b exp 0111", row_n);
    end
    wait_cyc(10);
    #1 clear = 1'b1;
    keys = '0;
    #1;
    checks++;
    if (op_selected !== 1'b0 || op_code !== 2'b00) begin
      errors++;
      $display("FAIL mid_deb_now: got %b/%b exp 0/00", op_selected, op_code);
    end
    wait_cyc(3);
    clear = 1'b0;
    wait_cyc(60);
    checks++;
    if (n_op - b_op != 0 || op_code !== 2'b00) begin
      errors++;
      $display("FAIL mid_deb_after: got n %0d op %b exp 0 00",
               n_op - b_op, op_code);
    end
  endtask

  task automatic test_exclusive;
    checks++;
    if (n_multi != 0) begin
      errors++; $display("FAIL pulse_exclusive: got %0d exp 0", n_multi);
    end
  endtask

  initial begin
    test_reset();
    test_digit();
    test_op_equal();
    test_digit_table();
    test_star();
    test_bounce();
    test_multi_key();
    test_reset_after_keys();
    test_reset_mid_debounce();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
